// File: rtl/e203_tb_pkg.sv
// Shared types and constants for the E203 testbench IRQ stimulus block:
// channel FSM encoding, LFSR width, tap mask and step helper.
package e203_tb_pkg;

    localparam int unsigned LFSR_W = 16;
    // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned BERR_LO_LOG2 = 4;
    localparam int unsigned BERR_HI_LOG2 = 7;
    localparam int unsigned BERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StAssert  = 2'd2,
        StStopped = 2'd3
    } chnl_st_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/e203_tb_irq_chnl.sv
// One IRQ stimulus channel: free-running LFSR, random wait counter and the
// IDLE/WAIT/ASSERT/STOPPED FSM driving a registered interrupt line.
module e203_tb_irq_chnl
    import e203_tb_pkg::*;
#(
    parameter int unsigned       WAIT_LOG2 = 10,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0001
) (
    input  logic clk,
    input  logic rst_n,
    input  logic armed_i,
    input  logic stop_i,
    input  logic ack_i,
    output logic irq_o
);

    localparam int unsigned CW = WAIT_LOG2 + 1;

    chnl_st_e          st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     load;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              irq_q, irq_d;

    always_comb begin
        load   = CW'(lfsr_q[WAIT_LOG2-1:0]) + CW'(1);
        lfsr_d = lfsr_step(lfsr_q);
        st_d   = st_q;
        cnt_d  = cnt_q;
        irq_d  = irq_q;
        case (st_q)
            StIdle: begin
                if (armed_i) begin
                    st_d  = StWait;
                    cnt_d = load;
                end
            end
            StWait: begin
                if (cnt_q == CW'(1)) begin
                    st_d  = StAssert;
                    irq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StAssert: begin
                // Stop is only honoured here, so a raised IRQ always waits for its ack.
                if (ack_i) begin
                    irq_d = 1'b0;
                    if (stop_i) begin
                        st_d = StStopped;
                    end else begin
                        st_d  = StWait;
                        cnt_d = load;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            cnt_q  <= '0;
            lfsr_q <= SEED;
            irq_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/e203_tb_irq_stim.sv
// E203 testbench IRQ stimulus: commit-PC triggers, statistics counters and N_CH
// random IRQ channels. Define E203_TB_BUSERR_INJ_EN to add the bus-error injector.
module e203_tb_irq_stim
    import e203_tb_pkg::*;
#(
    parameter int unsigned       N_CH      = 3,
    parameter int unsigned       PC_W      = 32,
    parameter int unsigned       CNT_W     = 32,
    parameter int unsigned       WAIT_LOG2 = 10,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int unsigned       STOP_CNT  = 32,
    parameter int unsigned       DONE_CNT  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmt_valid,
    input  logic [PC_W-1:0]        cmt_pc,
    input  logic                   exu_hs,
    input  logic [PC_W-1:0]        arm_pc,
    input  logic [PC_W-1:0]        tohost_pc,
    input  logic [N_CH*PC_W-1:0]   ack_pc,
`ifdef E203_TB_BUSERR_INJ_EN
    input  logic                   status_mie,
    input  logic                   itcm_rd,
    output logic                   berr_o,
`endif
    output logic [N_CH-1:0]        irq_o,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instret_cnt,
    output logic [CNT_W-1:0]       tohost_cnt,
    output logic [CNT_W-1:0]       tohost_cycle,
    output logic                   test_done
);

    localparam logic [CNT_W-1:0] StopC = CNT_W'(STOP_CNT);
    localparam logic [CNT_W-1:0] DoneC = CNT_W'(DONE_CNT);

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] th_cnt_q, th_cnt_d;
    logic [CNT_W-1:0] th_cyc_q, th_cyc_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             arm_hit, th_hit, stop;
    logic [N_CH-1:0]  ack_hit;

    assign arm_hit = cmt_valid & (cmt_pc == arm_pc);
    assign th_hit  = cmt_valid & (cmt_pc == tohost_pc);
    assign stop    = (th_cnt_q > StopC);

    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        th_cnt_d  = th_cnt_q;
        th_cyc_d  = th_cyc_q;
        instret_d = instret_q;
        if (th_hit && (th_cnt_q != '1)) begin
            th_cnt_d = th_cnt_q + CNT_W'(1);
        end
        // A zero count identifies the first hit since the counter never wraps.
        if (th_hit && (th_cnt_q == '0)) begin
            th_cyc_d = cycle_q;
        end
        if (exu_hs && (th_cnt_q == '0)) begin
            instret_d = instret_q + CNT_W'(1);
        end
        armed_d = armed_q | arm_hit;
        done_d  = done_q | ((th_cnt_q >= DoneC) && (irq_o == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
            th_cnt_q  <= '0;
            th_cyc_q  <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            th_cnt_q  <= th_cnt_d;
            th_cyc_q  <= th_cyc_d;
            armed_q   <= armed_d;
            done_q    <= done_d;
        end
    end

    assign cycle_cnt    = cycle_q;
    assign instret_cnt  = instret_q;
    assign tohost_cnt   = th_cnt_q;
    assign tohost_cycle = th_cyc_q;
    assign test_done    = done_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_chnl
        localparam logic [LFSR_W-1:0] ChSeed = seed_fix(SEED ^ LFSR_W'(k + 1));

        assign ack_hit[k] = cmt_valid & (cmt_pc == ack_pc[k*PC_W +: PC_W]);

        e203_tb_irq_chnl #(
            .WAIT_LOG2 (WAIT_LOG2),
            .SEED      (ChSeed)
        ) u_chnl (
            .clk     (clk),
            .rst_n   (rst_n),
            .armed_i (armed_q),
            .stop_i  (stop),
            .ack_i   (ack_hit[k]),
            .irq_o   (irq_o[k])
        );
    end

`ifdef E203_TB_BUSERR_INJ_EN
    localparam logic [LFSR_W-1:0] BerrSeed = seed_fix(SEED ^ 16'h5A5A);

    logic [LFSR_W-1:0]     blfsr_q, blfsr_d;
    logic                  bhi_q, bhi_d;
    logic [BERR_CNT_W-1:0] bcnt_q, bcnt_d;
    logic [BERR_CNT_W-1:0] lo_load, hi_load;

    always_comb begin
        lo_load = BERR_CNT_W'(blfsr_q[BERR_LO_LOG2-1:0]) + BERR_CNT_W'(1);
        hi_load = BERR_CNT_W'(blfsr_q[BERR_HI_LOG2-1:0]) + BERR_CNT_W'(1);
        blfsr_d = lfsr_step(blfsr_q);
        bhi_d   = bhi_q;
        bcnt_d  = bcnt_q;
        // A zero count means idle; the first armed cycle opens a low phase.
        if (!armed_q || stop) begin
            bhi_d  = 1'b0;
            bcnt_d = '0;
        end else if (bcnt_q == '0) begin
            bhi_d  = 1'b0;
            bcnt_d = lo_load;
        end else if (bcnt_q == BERR_CNT_W'(1)) begin
            bhi_d  = ~bhi_q;
            bcnt_d = bhi_q ? lo_load : hi_load;
        end else begin
            bcnt_d = bcnt_q - BERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blfsr_q <= BerrSeed;
            bhi_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blfsr_q <= blfsr_d;
            bhi_q   <= bhi_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign berr_o = bhi_q & status_mie & itcm_rd;
`endif

endmodule

// File: doc/e203_tb_irq_stim.md
E203_TB_IRQ_STIM -- requirements
Module: e203_tb_irq_stim

Interface
REQ-001 Parameter N_CH, default 3: number of independent IRQ stimulus channels (1..8).
REQ-002 Parameter PC_W, default 32: commit PC width.
REQ-003 Parameter CNT_W, default 32: width of all statistics counters.
REQ-004 Parameter WAIT_LOG2, default 10: random wait range is 1..2**WAIT_LOG2 cycles.
REQ-005 Parameter SEED, default 16'hACE1: base LFSR seed; channel k uses SEED ^ (k+1), with any zero result replaced by 16'h0001.
REQ-006 Parameter STOP_CNT, default 32: stop asserting IRQs once tohost_cnt > STOP_CNT.
REQ-007 Parameter DONE_CNT, default 8: tohost hit count that ends the test.
REQ-008 clk  in  1  single clock, all logic posedge.
REQ-009 rst_n  in  1  reset; synchronous and active-low.
REQ-010 cmt_valid  in  1  commit-stage instruction valid.
REQ-011 cmt_pc  in  PC_W  commit-stage PC.
REQ-012 exu_hs  in  1  EXU i_valid & i_ready handshake.
REQ-013 arm_pc  in  PC_W  PC that arms stimulus (after mtvec setup).
REQ-014 tohost_pc  in  PC_W  PC of the tohost write.
REQ-015 ack_pc  in  N_CH*PC_W  per-channel handler PC before mret, channel k at [k*PC_W +: PC_W].
REQ-016 irq_o  out  N_CH  forced interrupt lines.
REQ-017 cycle_cnt, instret_cnt, tohost_cnt, tohost_cycle  out  CNT_W each  statistics.
REQ-018 test_done  out  1  sticky; all channels quiet after DONE_CNT tohost hits.

Function
REQ-019 hit(x) = cmt_valid & (cmt_pc == x); all comparisons are on full PC_W.
REQ-020 cycle_cnt increments every cycle out of reset and wraps modulo 2**CNT_W.
REQ-021 tohost_cnt increments on each hit(tohost_pc) and saturates at all-ones.
REQ-022 On the first hit(tohost_pc), tohost_cycle captures the current cycle_cnt and then holds.
REQ-023 instret_cnt increments on exu_hs only while tohost_cnt == 0.
REQ-024 armed is set on the first hit(arm_pc) and remains set until reset.
REQ-025 stop = (tohost_cnt > STOP_CNT).
REQ-026 Each channel FSM has four states: IDLE, WAIT, ASSERT, STOPPED.
REQ-027 IDLE -> WAIT when armed; the wait counter loads (lfsr[WAIT_LOG2-1:0]) + 1.
REQ-028 WAIT decrements the counter each cycle; at 1 -> ASSERT; irq_o[k] rises on entry to ASSERT.
REQ-029 ASSERT holds irq_o[k]=1 until hit(ack_pc[k]); irq_o[k] drops the next cycle; then -> STOPPED if stop, else -> WAIT with a new random load.
REQ-030 Stop is checked only when leaving ASSERT; a pending IRQ is never withdrawn without its ack.
REQ-031 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing one step per cycle in every state; it never reaches zero.
REQ-032 test_done sets when tohost_cnt >= DONE_CNT and irq_o == 0 in the same cycle.
REQ-033 A hit(arm_pc) and a hit(ack_pc[k]) in the same cycle are both honoured.

Reset
REQ-034 When rst_n=0 at a posedge: all counters = 0; irq_o = 0; test_done = 0; armed = 0; all FSMs IDLE; LFSRs = seeds.
REQ-035 Reset asserted mid-ASSERT drops irq_o on the next posedge, and the channel restarts in IDLE requiring a re-arm.

Configuration
REQ-036 With E203_TB_BUSERR_INJ_EN defined, the block adds inputs status_mie and itcm_rd (1 bit each) and output berr_o (1 bit).
REQ-037 berr_o alternates between low phases (1..16 cycles) and high phases (1..128 cycles), both drawn from a separate LFSR; it starts after armed, stops when stop is true, and is gated by status_mie & itcm_rd.
REQ-038 With E203_TB_BUSERR_INJ_EN undefined, these ports and the associated logic are absent.

Structure
REQ-039 FSM state encoding, LFSR polynomial and width constants live in shared package e203_tb_pkg.
REQ-040 Per-channel FSM, LFSR and wait counter are one sub-module, e203_tb_irq_chnl, instantiated N_CH times with a generate loop.

Verification
REQ-041 Reset, no commits for 100 cycles -> cycle_cnt=100, irq_o=0, all FSMs IDLE.
REQ-042 N_CH=3, hit(arm_pc) at cycle 10 -> each irq_o[k] rises within 1..1024 cycles; rise cycles differ across channels for the default seed.
REQ-043 irq_o[1] high, hit(ack_pc[1]) at cycle T -> irq_o[1]=0 at T+1; irq_o[0] and irq_o[2] unchanged.
REQ-044 33 tohost hits, first at cycle 500 -> tohost_cycle=500, stop=1, each channel reaches STOPPED after its next ack, and no further rises occur.
REQ-045 rst_n=0 for one posedge while irq_o[2]=1 -> irq_o=0 and counters=0 on the next cycle; no IRQ occurs before a new hit(arm_pc).
REQ-046 Macro defined, status_mie=0 -> berr_o stays 0; status_mie=1 and itcm_rd=1 -> berr_o pulses, each high phase lasting <= 128 cycles.
